// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_PERF_CNT_EN (performance counters).
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam int CTRL_W = 21;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding source priority for one ID operand.
// Youngest producer wins; r0 and unused operands read the register file.
module hazard_fwd_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic [4:0] ex_dest,
    input  logic       ex_rf_le,
    input  logic       ex_is_load,
    input  logic [4:0] mem_dest,
    input  logic       mem_rf_le,
    input  logic [4:0] wb_dest,
    input  logic       wb_rf_le,
    output logic [1:0] fwd
);

    // EX > MEM > WB; a load in EX has no result yet
    always_comb begin
        fwd = FWD_RF;
        if (!use_rs || rs == 5'd0)
            fwd = FWD_RF;
        else if (ex_rf_le && !ex_is_load && ex_dest == rs)
            fwd = FWD_EX;
        else if (mem_rf_le && mem_dest == rs)
            fwd = FWD_MEM;
        else if (wb_rf_le && wb_dest == rs)
            fwd = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: stage enables, bubbles, IF/ID squash, forwarding.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush counters).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_SLOTS = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_a,
    input  logic [4:0] id_rs_b,
    input  logic [4:0] id_rs_d,
    input  logic       id_use_a,
    input  logic       id_use_b,
    input  logic       id_use_d,
    input  logic [4:0] ex_dest,
    input  logic [4:0] mem_dest,
    input  logic [4:0] wb_dest,
    input  logic       ex_rf_le,
    input  logic       mem_rf_le,
    input  logic       wb_rf_le,
    input  logic       ex_is_load,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_le,
    output logic       if_id_le,
    output logic       id_ex_le,
    output logic       ex_mem_le,
    output logic       mem_wb_le,
    output logic       ctrl_nop,
    output logic       if_id_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] fwd_d
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    hz_state_t  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [4:0] le;
    logic       mem_stall;
    logic       load_use;
    logic [1:0] raw_a, raw_b, raw_d;

    assign mem_stall = mem_req && !mem_ready;

    assign load_use = ex_is_load && ex_rf_le && ex_dest != 5'd0 &&
                      ((id_use_a && id_rs_a == ex_dest) ||
                       (id_use_b && id_rs_b == ex_dest) ||
                       (id_use_d && id_rs_d == ex_dest));

    assign {pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le} = le;

    hazard_fwd_sel u_fwd_a (
        .rs(id_rs_a), .use_rs(id_use_a),
        .ex_dest(ex_dest), .ex_rf_le(ex_rf_le), .ex_is_load(ex_is_load),
        .mem_dest(mem_dest), .mem_rf_le(mem_rf_le),
        .wb_dest(wb_dest), .wb_rf_le(wb_rf_le),
        .fwd(raw_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs(id_rs_b), .use_rs(id_use_b),
        .ex_dest(ex_dest), .ex_rf_le(ex_rf_le), .ex_is_load(ex_is_load),
        .mem_dest(mem_dest), .mem_rf_le(mem_rf_le),
        .wb_dest(wb_dest), .wb_rf_le(wb_rf_le),
        .fwd(raw_b)
    );

    hazard_fwd_sel u_fwd_d (
        .rs(id_rs_d), .use_rs(id_use_d),
        .ex_dest(ex_dest), .ex_rf_le(ex_rf_le), .ex_is_load(ex_is_load),
        .mem_dest(mem_dest), .mem_rf_le(mem_rf_le),
        .wb_dest(wb_dest), .wb_rf_le(wb_rf_le),
        .fwd(raw_d)
    );

    assign fwd_a = reset ? raw_a : FWD_RF;
    assign fwd_b = reset ? raw_b : FWD_RF;
    assign fwd_d = reset ? raw_d : FWD_RF;

    // Next state and stage controls; RAM wait outranks branch and load-use
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        le          = 5'b11111;
        ctrl_nop    = 1'b0;
        if_id_flush = 1'b0;
        unique case (state_q)
            ST_FLUSH: begin
                if (mem_stall) begin
                    le = 5'b00000;
                end else begin
                    ctrl_nop = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1)
                        state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // Held hazards are seen again from RUN once EX moves
                if (mem_stall)
                    le = 5'b00000;
                else
                    state_d = ST_RUN;
            end
            default: begin
                if (mem_stall) begin
                    le      = 5'b00000;
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    ctrl_nop    = 1'b1;
                    if_id_flush = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 2'(FLUSH_SLOTS - 1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (load_use) begin
                    le       = 5'b00111;
                    ctrl_nop = 1'b1;
                    state_d  = ST_LD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
        if (!reset) begin
            le          = 5'b00000;
            ctrl_nop    = 1'b1;
            if_id_flush = 1'b1;
        end
    end

    // State and flush countdown registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating stall and squash counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_le && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (if_id_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_SLOTS=3.
// Counter checks are built only with HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs_a, id_rs_b, id_rs_d;
    logic       id_use_a, id_use_b, id_use_d;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       ex_rf_le, mem_rf_le, wb_rf_le;
    logic       ex_is_load, branch_taken, mem_req, mem_ready;
    logic       pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le;
    logic       ctrl_nop, if_id_flush;
    logic [1:0] fwd_a, fwd_b, fwd_d;
    logic [4:0] le;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign le = {pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le};

    pipeline_hazard_ctrl #(.FLUSH_SLOTS(3)) dut (
        .clk(clk), .reset(reset),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_d(id_rs_d),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_d(id_use_d),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .ex_rf_le(ex_rf_le), .mem_rf_le(mem_rf_le), .wb_rf_le(wb_rf_le),
        .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_le(pc_le), .if_id_le(if_id_le), .id_ex_le(id_ex_le),
        .ex_mem_le(ex_mem_le), .mem_wb_le(mem_wb_le),
        .ctrl_nop(ctrl_nop), .if_id_flush(if_id_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs_a = 5'd0; id_rs_b = 5'd0; id_rs_d = 5'd0;
        id_use_a = 1'b0; id_use_b = 1'b0; id_use_d = 1'b0;
        ex_dest = 5'd0; mem_dest = 5'd0; wb_dest = 5'd0;
        ex_rf_le = 1'b0; mem_rf_le = 1'b0; wb_rf_le = 1'b0;
        ex_is_load = 1'b0; branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_r5_use_b();
        ex_is_load = 1'b1; ex_rf_le = 1'b1; ex_dest = 5'd5;
        id_rs_b = 5'd5; id_use_b = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        ex_rf_le = 1'b1; ex_dest = 5'd7; id_rs_a = 5'd7; id_use_a = 1'b1;
        #2;
        chk("rst_le", 32'(le), 32'h00);
        chk("rst_nop", 32'(ctrl_nop), 32'd1);
        chk("rst_flush", 32'(if_id_flush), 32'd1);
        chk("rst_fwd_a", 32'(fwd_a), 32'd0);

        cyc(); cyc();
        reset = 1'b1; idle(); #1;
        chk("run_le", 32'(le), 32'h1f);
        chk("run_nop", 32'(ctrl_nop), 32'd0);
        chk("run_flush", 32'(if_id_flush), 32'd0);

        cyc(); idle();
        ex_rf_le = 1'b1; ex_dest = 5'd7;
        mem_rf_le = 1'b1; mem_dest = 5'd7;
        id_rs_a = 5'd7; id_use_a = 1'b1;
        id_rs_b = 5'd7; id_use_b = 1'b0;
        wb_rf_le = 1'b1; wb_dest = 5'd9;
        id_rs_d = 5'd9; id_use_d = 1'b1;
        #1;
        chk("fwd_a_ex", 32'(fwd_a), 32'd1);
        chk("fwd_b_unused", 32'(fwd_b), 32'd0);
        chk("fwd_d_wb", 32'(fwd_d), 32'd3);

        cyc();
        ex_dest = 5'd0; mem_dest = 5'd0; id_rs_a = 5'd0; #1;
        chk("fwd_a_r0", 32'(fwd_a), 32'd0);

        cyc(); idle();
        mem_rf_le = 1'b1; mem_dest = 5'd12;
        id_rs_b = 5'd12; id_use_b = 1'b1; #1;
        chk("fwd_b_mem", 32'(fwd_b), 32'd2);

        cyc(); idle(); load_r5_use_b(); #1;
        chk("lu_le", 32'(le), 32'h07);
        chk("lu_nop", 32'(ctrl_nop), 32'd1);
        chk("lu_fwd_b", 32'(fwd_b), 32'd0);

        cyc(); idle();
        mem_rf_le = 1'b1; mem_dest = 5'd5;
        id_rs_b = 5'd5; id_use_b = 1'b1; #1;
        chk("post_lu_le", 32'(le), 32'h1f);
        chk("post_lu_nop", 32'(ctrl_nop), 32'd0);
        chk("post_lu_fwd_b", 32'(fwd_b), 32'd2);

        cyc(); idle(); load_r5_use_b(); branch_taken = 1'b1; #1;
        chk("br_le", 32'(le), 32'h1f);
        chk("br_nop", 32'(ctrl_nop), 32'd1);
        chk("br_flush", 32'(if_id_flush), 32'd1);

        cyc(); #1;
        chk("fl1_le", 32'(le), 32'h1f);
        chk("fl1_nop", 32'(ctrl_nop), 32'd1);
        chk("fl1_flush", 32'(if_id_flush), 32'd0);

        cyc(); idle(); #1;
        chk("fl2_nop", 32'(ctrl_nop), 32'd1);
        chk("fl2_flush", 32'(if_id_flush), 32'd0);

        cyc(); #1;
        chk("fl_done_nop", 32'(ctrl_nop), 32'd0);
        chk("fl_done_le", 32'(le), 32'h1f);

        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); load_r5_use_b();
            mem_req = 1'b1; mem_ready = 1'b0; #1;
            chk($sformatf("mw%0d_le", i), 32'(le), 32'h00);
            chk($sformatf("mw%0d_nop", i), 32'(ctrl_nop), 32'd0);
        end
        cyc(); mem_ready = 1'b1; #1;
        chk("mw_rel_le", 32'(le), 32'h1f);
        chk("mw_rel_nop", 32'(ctrl_nop), 32'd0);
        cyc(); mem_req = 1'b0; mem_ready = 1'b0; #1;
        chk("mw_bub_le", 32'(le), 32'h07);
        chk("mw_bub_nop", 32'(ctrl_nop), 32'd1);

        cyc(); idle(); branch_taken = 1'b1; #1;
        chk("br2_flush", 32'(if_id_flush), 32'd1);
        cyc(); branch_taken = 1'b0; #1;
        chk("br2_in_flush_nop", 32'(ctrl_nop), 32'd1);
        reset = 1'b0; #1;
        chk("midrst_le", 32'(le), 32'h00);
        chk("midrst_nop", 32'(ctrl_nop), 32'd1);
        chk("midrst_flush", 32'(if_id_flush), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        cyc(); reset = 1'b1; #1;
        chk("after_rst_nop", 32'(ctrl_nop), 32'd0);
        chk("after_rst_le", 32'(le), 32'h1f);

`ifdef HAZARD_PERF_CNT_EN
        cyc(); load_r5_use_b(); #1;
        cyc(); idle(); #1;
        chk("stall_cnt_one", 32'(stall_cnt), 32'd1);
        chk("flush_cnt_zero", 32'(flush_cnt), 32'd0);
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
